// File: rtl/gray_pipe_pkg.sv
// gray_pipe_pkg: shared definitions for the GrayCounter method-to-pipe path.
//   PIPE_W / HDR_W / PAYLOAD_W : message geometry (16-bit header + 128-bit payload)
//   MID_*                      : method ids carried in header[7:0]
//   hdr_t                      : header layout {len[7:0], mid[7:0]}
package gray_pipe_pkg;
  localparam int PIPE_W    = 144;
  localparam int HDR_W     = 16;
  localparam int PAYLOAD_W = 128;

  // Ids 2 and 4 belong to readGray/readBin, which travel the other direction.
  localparam logic [7:0] MID_INCREMENT = 8'd0;
  localparam logic [7:0] MID_DECREMENT = 8'd1;
  localparam logic [7:0] MID_READGRAY  = 8'd2;
  localparam logic [7:0] MID_WRITEGRAY = 8'd3;
  localparam logic [7:0] MID_READBIN   = 8'd4;
  localparam logic [7:0] MID_WRITEBIN  = 8'd5;

  typedef struct packed {
    logic [7:0] len;  // payload length in 32-bit words
    logic [7:0] mid;  // method id
  } hdr_t;
endpackage

// File: rtl/m2p_fifo.sv
// m2p_fifo: generic synchronous FIFO with simultaneous push/pop.
//   CLK, nRST (sync, active-low) ; push_i/wdata_i write side ;
//   pop_i/rdata_o read side (rdata_o = head entry, stable until popped) ;
//   full_o / empty_o derived from the internal occupancy count.
// Push while full and pop while empty are ignored.
module m2p_fifo #(
  parameter int DATA_W = 144,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;  // idle, or push+pop cancel out
    endcase
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/gray_counter_m2p.sv
// gray_counter_m2p: marshals GrayCounter method calls into 144-bit pipe messages.
//   method_increment / decrement / writeGray / writeBin : __ENA in, __RDY out,
//     _v value in for the writes
//   pipe_enq__ENA / pipe_enq_v out, pipe_enq__RDY in : request pipe
//   err_multi : sticky, set when more than one method ENA is seen in a cycle
// Build option: define M2P_SEQNUM_EN to stamp an 8-bit sequence number into
// payload[127:120] of every enqueued message.
module gray_counter_m2p
  import gray_pipe_pkg::*;
#(
  parameter int width = 4,
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              method_increment__ENA,
  output logic              method_increment__RDY,
  input  logic              method_decrement__ENA,
  output logic              method_decrement__RDY,
  input  logic              method_writeGray__ENA,
  input  logic [width-1:0]  method_writeGray_v,
  output logic              method_writeGray__RDY,
  input  logic              method_writeBin__ENA,
  input  logic [width-1:0]  method_writeBin_v,
  output logic              method_writeBin__RDY,
  output logic              pipe_enq__ENA,
  output logic [PIPE_W-1:0] pipe_enq_v,
  input  logic              pipe_enq__RDY,
  output logic              err_multi
);
  logic                 fifo_full, fifo_empty;
  logic                 rdy, push, multi;
  logic [3:0]           ena;
  hdr_t                 hdr;
  logic [PAYLOAD_W-1:0] payload;
  logic                 err_multi_q;

  // RDY depends only on registered FIFO state, never on an ENA.
  assign rdy = !fifo_full;
  assign method_increment__RDY = rdy;
  assign method_decrement__RDY = rdy;
  assign method_writeGray__RDY = rdy;
  assign method_writeBin__RDY  = rdy;

  assign ena   = {method_writeBin__ENA, method_writeGray__ENA,
                  method_decrement__ENA, method_increment__ENA};
  assign multi = (ena & (ena - 4'd1)) != 4'd0;  // more than one bit set
  assign push  = (ena != 4'd0) && rdy;

`ifdef M2P_SEQNUM_EN
  logic [7:0] seq_q;
  always_ff @(posedge CLK) begin
    if (!nRST)     seq_q <= 8'd0;
    else if (push) seq_q <= seq_q + 8'd1;  // one step per enqueued call only
  end
`endif

  // Priority: writeBin > writeGray > decrement > increment.
  always_comb begin
    hdr     = '0;
    payload = '0;
    if (method_writeBin__ENA) begin
      hdr.mid = MID_WRITEBIN;
      hdr.len = 8'd1;
      payload[width-1:0] = method_writeBin_v;
    end else if (method_writeGray__ENA) begin
      hdr.mid = MID_WRITEGRAY;
      hdr.len = 8'd1;
      payload[width-1:0] = method_writeGray_v;
    end else if (method_decrement__ENA) begin
      hdr.mid = MID_DECREMENT;
    end else begin
      hdr.mid = MID_INCREMENT;
    end
`ifdef M2P_SEQNUM_EN
    payload[PAYLOAD_W-1:PAYLOAD_W-8] = seq_q;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!nRST)      err_multi_q <= 1'b0;
    else if (multi) err_multi_q <= 1'b1;
  end
  assign err_multi = err_multi_q;

  assign pipe_enq__ENA = !fifo_empty && pipe_enq__RDY;

  m2p_fifo #(.DATA_W(PIPE_W), .DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .nRST    (nRST),
    .push_i  (push),
    .wdata_i ({hdr, payload}),
    .pop_i   (pipe_enq__ENA),
    .rdata_o (pipe_enq_v),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule

// File: tb/tb_gray_counter_m2p.sv
module tb_gray_counter_m2p;
  localparam int W = 4;
  localparam int D = 4;

  logic         CLK = 1'b0, nRST = 1'b0;
  logic         inc_ena = 0, dec_ena = 0, wg_ena = 0, wb_ena = 0;
  logic [W-1:0] wg_v = '0, wb_v = '0;
  logic         inc_rdy, dec_rdy, wg_rdy, wb_rdy;
  logic         enq_ena, enq_rdy = 1'b1, err;
  logic [143:0] enq_v;

  int checks = 0, errors = 0, seq = 0;
  logic [143:0] expq[$];

  always #5 CLK = ~CLK;

  gray_counter_m2p #(.width(W), .DEPTH(D)) dut (
    .CLK(CLK), .nRST(nRST),
    .method_increment__ENA(inc_ena), .method_increment__RDY(inc_rdy),
    .method_decrement__ENA(dec_ena), .method_decrement__RDY(dec_rdy),
    .method_writeGray__ENA(wg_ena), .method_writeGray_v(wg_v), .method_writeGray__RDY(wg_rdy),
    .method_writeBin__ENA(wb_ena), .method_writeBin_v(wb_v), .method_writeBin__RDY(wb_rdy),
    .pipe_enq__ENA(enq_ena), .pipe_enq_v(enq_v), .pipe_enq__RDY(enq_rdy),
    .err_multi(err)
  );

  function automatic logic [143:0] mk(input logic [7:0] mid, input logic [7:0] len,
                                      input logic [W-1:0] val);
    logic [127:0] p;
    p = '0;
    p[W-1:0] = val;
`ifdef M2P_SEQNUM_EN
    p[127:120] = 8'(seq);
`endif
    return {len, mid, p};
  endfunction

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every transfer the DUT presents is popped against the scoreboard.
  // A transfer during reset is not committed, so it is skipped.
  always @(negedge CLK) begin
    if (nRST && enq_ena) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_msg: got %h want none", enq_v);
      end else begin
        chk("pipe_msg", enq_v, expq.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // kind is the method id: 0 inc, 1 dec, 3 writeGray, 5 writeBin.
  task automatic call(input int kind, input logic [W-1:0] val, input bit acc);
    chk("method_rdy", {140'd0, inc_rdy, dec_rdy, wg_rdy, wb_rdy}, acc ? 144'hF : 144'h0);
    case (kind)
      0: inc_ena = 1;
      1: dec_ena = 1;
      3: begin wg_ena = 1; wg_v = val; end
      default: begin wb_ena = 1; wb_v = val; end
    endcase
    if (acc) begin
      expq.push_back(mk(8'(kind), (kind >= 3) ? 8'd1 : 8'd0, (kind >= 3) ? val : '0));
      seq = (seq + 1) % 256;
    end
    @(posedge CLK);
    #1;
    inc_ena = 0; dec_ena = 0; wg_ena = 0; wb_ena = 0;
  endtask

  task automatic do_reset();
    nRST = 0;
    expq.delete();
    seq = 0;
    @(posedge CLK);
    #1;
    nRST = 1;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1;
    chk("reset_enq_ena", {143'd0, enq_ena}, 144'd0);
    chk("reset_rdy", {140'd0, inc_rdy, dec_rdy, wg_rdy, wb_rdy}, 144'hF);
    chk("reset_err", {143'd0, err}, 144'd0);

    call(0, '0, 1);
    chk("latency_enq_ena", {143'd0, enq_ena}, 144'd1);
    idle(2);

    do_reset();
    call(5, 4'hA, 1);
    call(0, '0, 1);
    idle(3);

    enq_rdy = 0;
    for (int i = 1; i <= 4; i++) call(3, W'(i), 1);
    call(3, 4'h5, 0);
    enq_rdy = 1;
    idle(6);

    enq_rdy = 0;
    for (int i = 5; i <= 7; i++) call(3, W'(i), 1);
    enq_rdy = 1;
    call(3, 4'h8, 1);
    enq_rdy = 0;
    call(3, 4'h9, 1);
    chk("full_after_simul", {140'd0, inc_rdy, dec_rdy, wg_rdy, wb_rdy}, 144'h0);
    enq_rdy = 1;
    idle(6);

    chk("multi_pre_err", {143'd0, err}, 144'd0);
    inc_ena = 1; wb_ena = 1; wb_v = 4'h3;
    expq.push_back(mk(8'd5, 8'd1, 4'h3));
    seq = (seq + 1) % 256;
    @(posedge CLK);
    #1;
    inc_ena = 0; wb_ena = 0;
    chk("err_multi_set", {143'd0, err}, 144'd1);
    idle(3);
    chk("err_multi_sticky", {143'd0, err}, 144'd1);

    enq_rdy = 0;
    call(0, '0, 1);
    call(1, '0, 1);
    enq_rdy = 1;
    do_reset();
    chk("rst_enq_ena", {143'd0, enq_ena}, 144'd0);
    chk("rst_rdy", {140'd0, inc_rdy, dec_rdy, wg_rdy, wb_rdy}, 144'hF);
    chk("rst_err", {143'd0, err}, 144'd0);
    idle(4);
    call(3, 4'h5, 1);
    idle(3);
    chk("scoreboard_drained", 144'(expq.size()), 144'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gray_counter_m2p.md
Name: gray_counter_m2p

Overview:
Method-to-pipe marshaller for the GrayCounter request interface. It is the host-side transmitter matching the P2M receiver in the l_top test harness.
- Accepts increment/decrement/writeGray/writeBin method calls.
- Encodes each call as one 144-bit pipe message (16-bit header + 128-bit payload).
- Buffers messages in a small FIFO and drives them onto the request pipe.

Parameters:
width, 4, counter value width in bits; legal range 1..120
DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
CLK  input  1  clock; all logic on rising edge
nRST  input  1  reset, synchronous, active-low
method$increment__ENA  input  1  increment call
method$increment__RDY  output  1  can accept increment
method$decrement__ENA  input  1  decrement call
method$decrement__RDY  output  1  can accept decrement
method$writeGray__ENA  input  1  writeGray call
method$writeGray$v  input  width  gray value
method$writeGray__RDY  output  1  can accept writeGray
method$writeBin__ENA  input  1  writeBin call
method$writeBin$v  input  width  binary value
method$writeBin__RDY  output  1  can accept writeBin
pipe$enq__ENA  output  1  message valid/transfer
pipe$enq$v  output  144  message {header[15:0], payload[127:0]}
pipe$enq__RDY  input  1  downstream can accept
err_multi  output  1  sticky flag: more than one ENA seen in one cycle

Behaviour:
Interface:
- One clock, CLK. Reset nRST is synchronous and active-low.

Reset (nRST=0 sampled at a rising edge):
- FIFO emptied, pointers and count set to 0, err_multi=0, sequence counter=0.
- Consequently pipe$enq__ENA=0 and all __RDY=1 after reset.

Ready:
- All four method __RDY = (count != DEPTH).
- Driven from registered count only; never combinational from any ENA.

Encoding (pipe$enq$v bits):
- [143:128] header.
  - header[7:0] = method id: increment=0, decrement=1, writeGray=3, writeBin=5. Ids 2 and 4 are reserved for readGray/readBin and never emitted.
  - header[15:8] = payload length in 32-bit words: 0 for increment/decrement, 1 for writes.
- [width-1:0] = value for writes, 0 otherwise.
- All other payload bits 0, except when the Optional Feature is enabled.

Enqueue:
- An ENA with RDY=1 writes one encoded entry at the next edge.
- The caller must assert at most one ENA per cycle.
- If several are asserted, only the highest-priority one is enqueued (writeBin > writeGray > decrement > increment); the rest are dropped and err_multi sets.
- err_multi clears only on reset.
- ENA while RDY=0 is ignored; no state change.

Dequeue:
- pipe$enq__ENA = (count != 0) && pipe$enq__RDY.
- pipe$enq$v = head entry; it must hold stable while ENA=0.
- A transfer occurs on any cycle with ENA=1, and the head pops at that edge.
- Latency: an empty FIFO with RDY high emits a message 1 cycle after the call (registered, no bypass).

Boundary conditions:
- Push and pop in the same cycle: count unchanged, both pointers advance. This includes count=DEPTH-1.
- Full: RDY=0, so no push can coincide with a full FIFO.
- Pointers wrap modulo DEPTH.
- Reset mid-transfer: all queued messages are discarded, and the transfer in that cycle is not committed by this block.

Optional Feature:
Macro M2P_SEQNUM_EN.
- Defined:
  - 8-bit sequence counter; payload[127:120] = its value at enqueue.
  - Counter increments per accepted (enqueued) call and wraps 255 -> 0.
  - Dropped multi-ENA calls do not increment it.
- Not defined:
  - payload[127:120] = 0, and no counter register is present.

Decomposition:
- Package gray_pipe_pkg:
  - PIPE_W=144, HDR_W=16, PAYLOAD_W=128
  - method id localparams (MID_INCREMENT=0 .. MID_WRITEBIN=5)
  - header typedef struct {len[7:0], mid[7:0]}
- Sub-module m2p_fifo: generic synchronous FIFO (DATA_W, DEPTH) with count, full, empty, simultaneous push/pop support.
- gray_counter_m2p holds the encoder, priority/error logic and the sequence counter.

Test Plan:
- Reset, then single increment with pipe$enq__RDY=1 -> next cycle pipe$enq__ENA=1, v[143:128]=16'h0000, payload=0.
- writeBin v=4'hA, RDY=1 -> header=16'h0105, v[3:0]=4'hA, v[127:4]=0; with M2P_SEQNUM_EN, v[127:120]=0, and the next message carries 1.
- pipe$enq__RDY=0, issue 4 writeGray 1,2,3,4 -> 4th accepted, __RDY=0 after; a 5th call is ignored. Raise pipe$enq__RDY -> messages out in order 1,2,3,4 with header 16'h0103.
- Fill to 3 entries, then a call and a pop in the same cycle -> count stays 3; order preserved.
- Assert increment and writeBin together -> only writeBin (id 5) is enqueued; err_multi=1 and stays set until reset.
- 2 entries queued, assert nRST=0 for one cycle -> pipe$enq__ENA=0, all __RDY=1, err_multi=0, and no stale message afterwards.
